apb_lockstep_checker: RTL

//  Synthesizable run-time successor to the two-DUT formal equivalence properties. Observes one APB

---
 rtl/apb_lockstep_pkg.sv | 16 +
 rtl/apb_lockstep_cmp.sv | 30 +++
 rtl/apb_lockstep_checker.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/apb_lockstep_pkg.sv
// Shared types for the APB lockstep checker: phase encoding and per-DUT field mismatch mask.
package apb_lockstep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } phase_e;

  localparam int FIELD_PREADY  = 0;
  localparam int FIELD_PRDATA  = 1;
  localparam int FIELD_PSLVERR = 2;

  typedef logic [2:0] field_mask_t;

endpackage

// File: rtl/apb_lockstep_cmp.sv
// Compares one DUT response channel against the golden channel and reports which fields differ.
module apb_lockstep_cmp
  import apb_lockstep_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  cmp_rdy,
  input  logic                  cmp_data,
  input  logic                  rd,
  input  logic                  gold_pready,
  input  logic [DATA_WIDTH-1:0] gold_prdata,
  input  logic                  gold_pslverr,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr,
  output logic [2:0]            mask
);

  field_mask_t m;

  always_comb begin
    m                = '0;
    m[FIELD_PREADY]  = cmp_rdy && (pready != gold_pready);
    m[FIELD_PRDATA]  = cmp_data && rd && (prdata != gold_prdata);
    m[FIELD_PSLVERR] = cmp_data && (pslverr != gold_pslverr);
  end

  assign mask = m;

endmodule

// File: rtl/apb_lockstep_checker.sv
// Run-time lockstep checker: tracks APB phase on the shared request, compares every DUT response
// against DUT 0, and records protocol errors, timeouts, the first mismatch and saturating counts.
module apb_lockstep_checker
  import apb_lockstep_pkg::*;
#(
  parameter int NUM_DUTS   = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int MAX_WAIT   = 16,
  parameter int STRICT     = 0
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [NUM_DUTS-1:0]            dut_pready,
  input  logic [NUM_DUTS*DATA_WIDTH-1:0] dut_prdata,
  input  logic [NUM_DUTS-1:0]            dut_pslverr,
  input  logic                           clear,
  output logic                           mismatch,
  output logic                           mismatch_seen,
  output logic [$clog2(NUM_DUTS)-1:0]    first_dut,
  output logic [2:0]                     first_fields,
  output logic [ADDR_WIDTH-1:0]          first_addr,
  output logic [CNT_WIDTH-1:0]           mismatch_count,
  output logic [CNT_WIDTH-1:0]           xfer_count,
  output logic                           protocol_err,
  output logic                           timeout_err
);

  localparam int IDX_W  = $clog2(NUM_DUTS);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic access_ph, setup_ph, idle_ph, done, cmp_data;
  assign idle_ph   = !PSEL;
  assign setup_ph  = PSEL && !PENABLE;
  assign access_ph = PSEL && PENABLE;
  assign done      = access_ph && dut_pready[0];
  assign cmp_data  = access_ph && ((STRICT != 0) || dut_pready[0]);

  logic [NUM_DUTS-1:1][2:0] masks;

  for (genvar g = 1; g < NUM_DUTS; g++) begin : g_cmp
    apb_lockstep_cmp #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
      .cmp_rdy      (access_ph),
      .cmp_data     (cmp_data),
      .rd           (!PWRITE),
      .gold_pready  (dut_pready[0]),
      .gold_prdata  (dut_prdata[0 +: DATA_WIDTH]),
      .gold_pslverr (dut_pslverr[0]),
      .pready       (dut_pready[g]),
      .prdata       (dut_prdata[g*DATA_WIDTH +: DATA_WIDTH]),
      .pslverr      (dut_pslverr[g]),
      .mask         (masks[g])
    );
  end

  logic             any;
  logic [IDX_W-1:0] hit_idx;
  logic [2:0]       hit_mask;

  assign any = |masks;

  // Scan downward so the lowest mismatching index is the one left standing.
  always_comb begin
    hit_idx  = '0;
    hit_mask = '0;
    for (int i = NUM_DUTS - 1; i >= 1; i--) begin
      if (|masks[i]) begin
        hit_idx  = IDX_W'(i);
        hit_mask = masks[i];
      end
    end
  end

  phase_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q, rdy_q, latch, legal_acc, perr_ev, tmo_ev;
  logic [WAIT_W-1:0]     wait_q, wait_d;

  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    legal_acc = 1'b0;
    perr_ev   = 1'b0;
    tmo_ev    = 1'b0;
    wait_d    = '0;
    case (state_q)
      IDLE: begin
        if (setup_ph) state_d = SETUP;
        else if (access_ph) perr_ev = 1'b1;
      end
      SETUP: begin
        if (access_ph) begin
          state_d   = ACCESS;
          latch     = 1'b1;
          legal_acc = 1'b1;
        end else begin
          state_d = IDLE;
          perr_ev = 1'b1;
        end
      end
      ACCESS: begin
        if (rdy_q) begin
          if (idle_ph) state_d = IDLE;
          else if (setup_ph) state_d = SETUP;
          else begin
            state_d = IDLE;
            perr_ev = 1'b1;
          end
        end else if (access_ph && PADDR == addr_q && PWRITE == write_q) begin
          legal_acc = 1'b1;
        end else begin
          state_d = IDLE;
          perr_ev = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Wait states only accumulate while a legitimately started transfer is stalled.
    if (legal_acc && !dut_pready[0]) begin
      if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
        tmo_ev  = 1'b1;
        state_d = IDLE;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      write_q        <= 1'b0;
      rdy_q          <= 1'b0;
      wait_q         <= '0;
      mismatch       <= 1'b0;
      mismatch_seen  <= 1'b0;
      first_dut      <= '0;
      first_fields   <= '0;
      first_addr     <= '0;
      mismatch_count <= '0;
      xfer_count     <= '0;
      protocol_err   <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= done;
      wait_q   <= wait_d;
      mismatch <= any;
      if (latch) begin
        addr_q  <= PADDR;
        write_q <= PWRITE;
      end

      // A same-cycle event takes priority over clear for every sticky/counter.
      if (any) mismatch_count <= clear ? CNT_WIDTH'(1) :
                                 (&mismatch_count) ? mismatch_count : mismatch_count + CNT_WIDTH'(1);
      else if (clear) mismatch_count <= '0;

      if (done) xfer_count <= clear ? CNT_WIDTH'(1) :
                              (&xfer_count) ? xfer_count : xfer_count + CNT_WIDTH'(1);
      else if (clear) xfer_count <= '0;

      if (perr_ev) protocol_err <= 1'b1;
      else if (clear) protocol_err <= 1'b0;

      if (tmo_ev) timeout_err <= 1'b1;
      else if (clear) timeout_err <= 1'b0;

      if (any && (!mismatch_seen || clear)) begin
        mismatch_seen <= 1'b1;
        first_dut     <= hit_idx;
        first_fields  <= hit_mask;
        first_addr    <= PADDR;
      end else if (clear) begin
        mismatch_seen <= 1'b0;
        first_dut     <= '0;
        first_fields  <= '0;
        first_addr    <= '0;
      end
    end
  end

endmodule
